// File: rtl/fgen_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the clkdiv divider from a start to a stop value, holding each step for dwell+1 waveform periods.
// Latency: config is visible one cycle after start; each divider update is visible one cycle after the period_tick that triggers it.
// Backpressure: none; start is ignored while busy, and a done pulse reports completion.
// Optional feature macro FGEN_SWEEP_PINGPONG_EN adds a 'pingpong' input that makes the sweep bounce endlessly between start and stop.
module fgen_sweep_ctrl #(
  parameter int DIV_W   = 6,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               period_tick,
  input  logic [SEL_W-1:0]   wave_in,
  input  logic [DIV_W-1:0]   div_start,
  input  logic [DIV_W-1:0]   div_stop,
  input  logic [DIV_W-1:0]   step_sz,
  input  logic [DWELL_W-1:0] dwell,
`ifdef FGEN_SWEEP_PINGPONG_EN
  input  logic               pingpong,
`endif
  output logic [SEL_W-1:0]   sel,
  output logic [DIV_W-1:0]   div,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Controller state and registered outputs.
  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [DIV_W-1:0]   r_div;
  logic               r_busy;
  logic               r_done;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_dir;       // 1 = counting up, 0 = counting down
  logic               r_fwd;       // 1 = forward leg (toward stop), 0 = return leg (toward start)

  // Shadow copy of the configuration, captured at start so live pin changes cannot disturb a sweep.
  logic [DIV_W-1:0]   r_org;
  logic [DIV_W-1:0]   r_stop;
  logic [DIV_W-1:0]   r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [SEL_W-1:0]   r_wave;
  logic               r_pp;

  logic [DIV_W:0]     w_step;
  logic [DIV_W-1:0]   w_term;
  logic [DIV_W-1:0]   w_term_back;
  logic [DIV_W-1:0]   w_div_next;
  logic [DIV_W-1:0]   w_div_turn;
  logic               w_pp_in;

`ifdef FGEN_SWEEP_PINGPONG_EN
  assign w_pp_in = pingpong;
`else
  assign w_pp_in = 1'b0;
`endif

  // Move cur one step toward term, in DIV_W+1 bits, landing exactly on term instead of passing or wrapping.
  function automatic logic [DIV_W-1:0] step_toward(
    input logic [DIV_W-1:0] cur,
    input logic [DIV_W:0]   stp,
    input logic [DIV_W-1:0] term,
    input logic             up
  );
    logic [DIV_W:0]   ext;
    logic [DIV_W-1:0] res;
    if (up) begin
      ext = {1'b0, cur} + stp;
      if (ext > {1'b0, term}) res = term;
      else                    res = ext[DIV_W-1:0];
    end else begin
      ext = {1'b0, cur} - stp;
      // MSB set means the subtraction borrowed below zero.
      if (ext[DIV_W] || (ext < {1'b0, term})) res = term;
      else                                    res = ext[DIV_W-1:0];
    end
    return res;
  endfunction

  // Step size of zero would stall the sweep forever, so it is treated as one.
  always_comb begin
    w_step = {1'b0, r_step};
    if (r_step == '0) w_step = {{DIV_W{1'b0}}, 1'b1};
  end

  // Terminal of the current leg, plus the next divider in both the current and the reversed direction.
  always_comb begin
    w_term      = r_fwd ? r_stop : r_org;
    w_term_back = r_fwd ? r_org  : r_stop;
    w_div_next  = step_toward(r_div, w_step, w_term, r_dir);
    w_div_turn  = step_toward(r_div, w_step, w_term_back, ~r_dir);
  end

  // Sweep FSM; priority is rst, then abort, then start, then period_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_div       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dwell_cnt <= '0;
      r_dir       <= 1'b1;
      r_fwd       <= 1'b1;
      r_org       <= '0;
      r_stop      <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_wave      <= '0;
      r_pp        <= 1'b0;
    end else if (abort) begin
      // Divider holds its last value so the datapath sees no frequency jump; the mute select silences it.
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dwell_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // period_tick is deliberately ignored here, even in the same cycle as start.
          if (start) begin
            r_org       <= div_start;
            r_stop      <= div_stop;
            r_step      <= step_sz;
            r_dwell     <= dwell;
            r_wave      <= wave_in;
            r_pp        <= w_pp_in;
            r_div       <= div_start;
            r_sel       <= wave_in;
            r_busy      <= 1'b1;
            r_dwell_cnt <= '0;
            r_dir       <= (div_start <= div_stop);
            r_fwd       <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          // Only period boundaries advance the sweep, so div never changes mid-waveform.
          if (period_tick) begin
            if (r_dwell_cnt != r_dwell) begin
              r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end else begin
              r_dwell_cnt <= '0;
              if (r_div == w_term) begin
                if (r_pp) begin
                  r_dir <= ~r_dir;
                  r_fwd <= ~r_fwd;
                  r_div <= w_div_turn;
                end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_sel   <= '0;
                end
              end else begin
                r_div <= w_div_next;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = r_sel;
  assign div  = r_div;
  assign busy = r_busy;
  assign done = r_done;

  // The shadow wave select is consumed at start; the copy is kept for visibility in the register map.
  logic w_unused_wave;
  assign w_unused_wave = ^r_wave;

endmodule

// File: tb/tb_fgen_sweep_ctrl.sv
// Directed bench for fgen_sweep_ctrl: reset, up/down sweeps with clamping, edge configs, abort, ignored start.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// The pingpong leg is exercised only when FGEN_SWEEP_PINGPONG_EN is defined.
module tb_fgen_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       period_tick = 1'b0;
  logic [1:0] wave_in = '0;
  logic [5:0] div_start = '0;
  logic [5:0] div_stop = '0;
  logic [5:0] step_sz = '0;
  logic [3:0] dwell = '0;
`ifdef FGEN_SWEEP_PINGPONG_EN
  logic       pingpong = 1'b0;
`endif
  logic [1:0] sel;
  logic [5:0] div;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  int exp_up[6]   = '{2, 5, 5, 8, 8, 8};
  int exp_down[3] = '{6, 2, 1};
  int exp_pp[4]   = '{4, 6, 4, 2};

  fgen_sweep_ctrl #(.DIV_W(6), .SEL_W(2), .DWELL_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .period_tick (period_tick),
    .wave_in     (wave_in),
    .div_start   (div_start),
    .div_stop    (div_stop),
    .step_sz     (step_sz),
    .dwell       (dwell),
`ifdef FGEN_SWEEP_PINGPONG_EN
    .pingpong    (pingpong),
`endif
    .sel         (sel),
    .div         (div),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    period_tick = 1'b1;
    cyc();
    period_tick = 1'b0;
  endtask

  task automatic cfg(input int ds, input int dst, input int st, input int dw, input int wv);
    div_start = 6'(ds);
    div_stop  = 6'(dst);
    step_sz   = 6'(st);
    dwell     = 4'(dw);
    wave_in   = 2'(wv);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    // Reset then idle
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_sel",  32'(sel),  0);
    chk("rst_div",  32'(div),  0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_done", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
    end
    chk("idle_div", 32'(div), 0);

    // Basic up sweep 2 -> 8 step 3 dwell 1
    cfg(2, 8, 3, 1, 1);
    pulse_start();
    chk("up_div0", 32'(div),  2);
    chk("up_sel",  32'(sel),  1);
    chk("up_busy", 32'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("up_div", 32'(div), 32'(exp_up[i]));
      if (i < 5) chk("up_done_lo", 32'(done), 0);
    end
    chk("up_done",     32'(done), 1);
    chk("up_busy_lo",  32'(busy), 0);
    chk("up_sel_mute", 32'(sel),  0);
    cyc();
    chk("up_done_clr", 32'(done), 0);
    chk("up_div_hold", 32'(div),  8);

    // Clamped down sweep 10 -> 1 step 4 dwell 0
    cfg(10, 1, 4, 0, 2);
    pulse_start();
    chk("dn_div0", 32'(div), 10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dn_div",     32'(div),  32'(exp_down[i]));
      chk("dn_done_lo", 32'(done), 0);
    end
    tick();
    chk("dn_done",     32'(done), 1);
    chk("dn_div_last", 32'(div),  1);
    cyc();

    // step 0, start == stop == 5, dwell 2
    cfg(5, 5, 0, 2, 3);
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("eq_div",     32'(div),  5);
      chk("eq_done_lo", 32'(done), 0);
    end
    tick();
    chk("eq_done", 32'(done), 1);
    chk("eq_div_last", 32'(div), 5);
    cyc();

    // start coinciding with period_tick in IDLE, then abort at div 5
    cfg(2, 8, 3, 1, 1);
    start = 1'b1;
    period_tick = 1'b1;
    cyc();
    start = 1'b0;
    period_tick = 1'b0;
    chk("co_div0", 32'(div), 2);
    tick();
    chk("co_hold", 32'(div), 2);
    tick();
    chk("co_step", 32'(div), 5);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_sel",  32'(sel),  0);
    chk("ab_div",  32'(div),  5);
    chk("ab_done", 32'(done), 0);
    tick();
    chk("ab_done2", 32'(done), 0);
    chk("ab_div2",  32'(div),  5);

    // start during RUN is ignored
    cfg(2, 8, 3, 0, 2);
    pulse_start();
    tick();
    chk("ig_div1", 32'(div), 5);
    cfg(20, 30, 1, 5, 1);
    pulse_start();
    chk("ig_div_keep", 32'(div), 5);
    chk("ig_sel_keep", 32'(sel), 2);
    tick();
    chk("ig_div2", 32'(div), 8);
    tick();
    chk("ig_done", 32'(done), 1);
    cyc();

    // rst mid-sweep
    cfg(2, 8, 3, 0, 1);
    pulse_start();
    tick();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_div",  32'(div),  0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_sel",  32'(sel),  0);
    chk("mr_done", 32'(done), 0);

`ifdef FGEN_SWEEP_PINGPONG_EN
    // Ping-pong 2 <-> 6 step 2 dwell 0
    cfg(2, 6, 2, 0, 1);
    pingpong = 1'b1;
    pulse_start();
    pingpong = 1'b0;
    chk("pp_div0", 32'(div), 2);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("pp_div",  32'(div),  32'(exp_pp[i % 4]));
      chk("pp_done", 32'(done), 0);
    end
    chk("pp_busy", 32'(busy), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("pp_ab_busy", 32'(busy), 0);
    chk("pp_ab_sel",  32'(sel),  0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
